// File: rtl/qpsk_pkg.sv
// Shared types and helpers for the QPSK transmit scheduler.
package qpsk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_PRE  = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [1:0] PH_0   = 2'd0;
  localparam logic [1:0] PH_90  = 2'd1;
  localparam logic [1:0] PH_180 = 2'd2;
  localparam logic [1:0] PH_270 = 2'd3;

  // Gray dibit {I,Q} to quarter-period phase offset.
  function automatic logic [1:0] gray_phase(input logic [1:0] dibit);
    logic [1:0] ph;
    ph = PH_0;
    case (dibit)
      2'b00:   ph = PH_0;
      2'b01:   ph = PH_90;
      2'b11:   ph = PH_180;
      2'b10:   ph = PH_270;
      default: ph = PH_0;
    endcase
    return ph;
  endfunction

  // Preamble alternates 0,180,0,180,... starting at 0.
  function automatic logic [1:0] pre_phase(input logic odd_sym);
    return odd_sym ? PH_180 : PH_0;
  endfunction

endpackage

// File: rtl/sym_tick_gen.sv
// Symbol tick counter modulo P_CYC; flags are registered and describe the current count.
module sym_tick_gen #(
  parameter int unsigned P_CYC = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic sym_first,
  output logic sym_last
);

  localparam int unsigned CNT_W = (P_CYC > 1) ? $clog2(P_CYC) : 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = (cnt == CNT_W'(P_CYC - 1)) ? '0 : cnt + CNT_W'(1);
    if (clr) cnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      sym_first <= 1'b1;
      sym_last  <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      sym_first <= (cnt_nxt == '0);
      sym_last  <= (cnt_nxt == CNT_W'(P_CYC - 1));
    end
  end

endmodule

// File: rtl/qpsk_tx_sched.sv
// QPSK symbol scheduler driving the 4-phase carrier generator.
// Optional preamble: define QPSK_TX_SCHED_PREAMBLE_EN.
module qpsk_tx_sched
  import qpsk_pkg::*;
#(
  parameter int unsigned SPS_CYC = 2,
  parameter int unsigned PRE_LEN = 8,
  parameter int unsigned LEN_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             in_valid,
  input  logic [1:0]       in_dibit,
  output logic             in_ready,
  output logic             car_en,
  output logic             car_sync,
  output logic [1:0]       car_phase,
  output logic             sym_stb,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  localparam int unsigned P = 4 * SPS_CYC;

  state_e           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] data_cnt;
  logic             sym_first;
  logic             sym_last;
  logic             tick_clr;
  logic [1:0]       data_ph_c;
  logic             miss_c;

`ifdef QPSK_TX_SCHED_PREAMBLE_EN
  localparam int unsigned PRE_W = $clog2(PRE_LEN + 1);
  logic [PRE_W-1:0] pre_cnt;
`else
  // PRE_LEN only shapes the preamble, so nothing is built from it here.
  if (PRE_LEN == 0) begin : g_no_pre
  end
`endif

  // Counter is held at 0 outside a frame so the first symbol lines up with SYNC+1.
  assign tick_clr = (state == ST_IDLE) || (state == ST_DONE);

  sym_tick_gen #(.P_CYC(P)) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (tick_clr),
    .sym_first (sym_first),
    .sym_last  (sym_last)
  );

  // Phase of the data symbol that starts on the next cycle; a missing dibit sends 0.
  assign miss_c    = in_ready && !in_valid;
  assign data_ph_c = (in_ready && in_valid) ? gray_phase(in_dibit) : PH_0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      data_cnt  <= '0;
      in_ready  <= 1'b0;
      car_en    <= 1'b0;
      car_sync  <= 1'b0;
      car_phase <= PH_0;
      sym_stb   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      underrun  <= 1'b0;
`ifdef QPSK_TX_SCHED_PREAMBLE_EN
      pre_cnt   <= '0;
`endif
    end else begin
      sym_stb  <= 1'b0;
      car_sync <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          in_ready  <= 1'b0;
          car_en    <= 1'b0;
          car_phase <= PH_0;
          if (start) begin
            busy     <= 1'b1;
            underrun <= 1'b0;
            if (frame_len == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              len_q    <= frame_len;
              state    <= ST_SYNC;
              car_sync <= 1'b1;
`ifndef QPSK_TX_SCHED_PREAMBLE_EN
              in_ready <= 1'b1;
`endif
            end
          end
        end

        ST_SYNC: begin
          car_en   <= 1'b1;
          sym_stb  <= 1'b1;
          in_ready <= 1'b0;
`ifdef QPSK_TX_SCHED_PREAMBLE_EN
          state     <= ST_PRE;
          car_phase <= pre_phase(1'b0);
          pre_cnt   <= PRE_W'(1);
`else
          state     <= ST_DATA;
          car_phase <= data_ph_c;
          underrun  <= underrun | miss_c;
          data_cnt  <= LEN_W'(1);
`endif
        end

`ifdef QPSK_TX_SCHED_PREAMBLE_EN
        ST_PRE: begin
          if (sym_first) begin
            sym_stb <= 1'b1;
            if (pre_cnt == PRE_W'(PRE_LEN)) begin
              state     <= ST_DATA;
              in_ready  <= 1'b0;
              car_phase <= data_ph_c;
              underrun  <= underrun | miss_c;
              data_cnt  <= LEN_W'(1);
            end else begin
              car_phase <= pre_phase(pre_cnt[0]);
              pre_cnt   <= pre_cnt + PRE_W'(1);
            end
          end else if (sym_last) begin
            in_ready <= (pre_cnt == PRE_W'(PRE_LEN));
          end
        end
`endif

        ST_DATA: begin
          if (sym_first) begin
            in_ready <= 1'b0;
            if (data_cnt == len_q) begin
              state     <= ST_DONE;
              done      <= 1'b1;
              car_en    <= 1'b0;
              car_phase <= PH_0;
            end else begin
              sym_stb   <= 1'b1;
              car_phase <= data_ph_c;
              underrun  <= underrun | miss_c;
              data_cnt  <= data_cnt + LEN_W'(1);
            end
          end else if (sym_last) begin
            in_ready <= (data_cnt != len_q);
          end
        end

        ST_DONE: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
          car_en    <= 1'b0;
          car_phase <= PH_0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qpsk_tx_sched.sv
// Directed bench for qpsk_tx_sched: P=8, PRE_LEN=4; timing follows the preamble build macro.
module tb_qpsk_tx_sched;

  localparam int unsigned SPS = 2;
  localparam int unsigned PRE = 4;
  localparam int unsigned LW  = 8;
  localparam int          P   = 8;
`ifdef QPSK_TX_SCHED_PREAMBLE_EN
  localparam int NPRE = 4;
`else
  localparam int NPRE = 0;
`endif
  localparam int RST_J = (NPRE > 0) ? 40 : 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] frame_len = '0;
  logic          in_valid = 1'b0;
  logic [1:0]    in_dibit = 2'b00;
  logic          in_ready;
  logic          car_en;
  logic          car_sync;
  logic [1:0]    car_phase;
  logic          sym_stb;
  logic          busy;
  logic          done;
  logic          underrun;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  qpsk_tx_sched #(.SPS_CYC(SPS), .PRE_LEN(PRE), .LEN_W(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .frame_len (frame_len),
    .in_valid  (in_valid),
    .in_dibit  (in_dibit),
    .in_ready  (in_ready),
    .car_en    (car_en),
    .car_sync  (car_sync),
    .car_phase (car_phase),
    .sym_stb   (sym_stb),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun)
  );

  // {in_ready, car_en, car_sync, car_phase, sym_stb, busy, done, underrun}
  function automatic logic [8:0] obs_vec();
    return {in_ready, car_en, car_sync, car_phase, sym_stb, busy, done, underrun};
  endfunction

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b (rdy en sync ph stb busy done und)", tag, obs, exp);
    end
  endtask

  // One frame from start at cycle t; every cycle t+1..t+D+1 is compared.
  task automatic run_frame(input string name, input int n, input logic [5:0] dib,
                           input logic [5:0] ph, input logic [2:0] vmask,
                           input int inj_j, input int rst_j);
    int d_len;
    int s_miss;
    int dn;
    int k;
    logic e_rdy, e_en, e_sync, e_stb, e_busy, e_done, e_und;
    logic [1:0] e_ph;
    d_len  = (n == 0) ? 1 : 2 + (NPRE + n) * P;
    s_miss = 1 << 30;
    for (int d = n - 1; d >= 0; d--)
      if (!vmask[d]) s_miss = 2 + (NPRE + d) * P;
    @(negedge clk);
    start     = 1'b1;
    frame_len = LW'(n);
    for (int j = 1; j <= d_len + 1; j++) begin
      @(negedge clk);
      start = (j == inj_j);
      dn = 0;
      while (dn < n && (1 + (NPRE + dn) * P) < j) dn++;
      in_valid = (dn < n) ? vmask[dn] : 1'b0;
      in_dibit = (dn < n) ? dib[2*dn +: 2] : 2'b00;
      if (j == rst_j) begin
        rst_n = 1'b0;
        #1;
        check($sformatf("%s_rst@%0d", name, j), obs_vec(), 9'b0);
        start    = 1'b0;
        in_valid = 1'b0;
        return;
      end
      e_busy = (j <= d_len);
      e_done = (j == d_len);
      e_sync = (j == 1) && (n != 0);
      e_en   = (j >= 2) && (j < d_len);
      e_stb  = e_en && (((j - 2) % P) == 0);
      e_ph   = 2'd0;
      if (e_en) begin
        k = (j - 2) / P;
        if (k < NPRE) e_ph = (k % 2 == 1) ? 2'd2 : 2'd0;
        else          e_ph = ph[2*(k-NPRE) +: 2];
      end
      e_rdy = 1'b0;
      for (int d = 0; d < n; d++)
        if (j == 1 + (NPRE + d) * P) e_rdy = 1'b1;
      e_und = (j >= s_miss);
      check($sformatf("%s@%0d", name, j), obs_vec(),
            {e_rdy, e_en, e_sync, e_ph, e_stb, e_busy, e_done, e_und});
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state, then idle after release with start low.
    repeat (3) @(negedge clk);
    check("reset", obs_vec(), 9'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("idle_%0d", i), obs_vec(), 9'b0);
    end

    // Dibits 00,01,11 -> phases 0,1,2.
    run_frame("basic", 3, 6'b11_01_00, 6'b10_01_00, 3'b111, 0, 0);

    // Empty frame: done one cycle after start, no carrier.
    run_frame("zero", 0, 6'b0, 6'b0, 3'b111, 0, 0);
    @(negedge clk);
    check("zero_after", obs_vec(), 9'b0);

    // Missing second dibit: phase 0 and sticky underrun.
    run_frame("under", 3, 6'b11_01_00, 6'b10_00_00, 3'b101, 0, 0);
    @(negedge clk);
    check("under_sticky", obs_vec(), 9'b0_0_0_00_0_0_0_1);

    // Next accepted start clears underrun.
    run_frame("clear", 3, 6'b11_01_00, 6'b10_01_00, 3'b111, 0, 0);

    // Start pulse during DATA is ignored.
    run_frame("inject", 3, 6'b11_01_00, 6'b10_01_00, 3'b111, 2 + NPRE * P + 3, 0);

    // Reset mid-frame, then a clean frame after release.
    run_frame("midrst", 3, 6'b11_01_00, 6'b10_01_00, 3'b111, 0, RST_J);
    @(negedge clk);
    check("midrst_hold", obs_vec(), 9'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_idle", obs_vec(), 9'b0);
    run_frame("after_rst", 3, 6'b11_01_00, 6'b10_01_00, 3'b111, 0, 0);

    // Dibits 10,11 -> phases 3,2.
    run_frame("len2", 2, 6'b00_11_10, 6'b00_10_11, 3'b011, 0, 0);

    repeat (2) @(negedge clk);
    check("final_idle", obs_vec(), 9'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qpsk_tx_sched.md
# qpsk_tx_sched

Symbol scheduler for the QPSK transmit path. It accepts a stream of dibits over a valid/ready handshake and sequences the 4-phase quadrature carrier generator (cos/sin period of 4 clk). For each symbol it drives enable, sync and a per-symbol phase offset into the generator, with an optional preamble. It sits between the framing logic and the carrier generator and is the only block that starts or stops the carrier.

## Interface
- SPS_CYC, 2: carrier periods per symbol; symbol period P = 4*SPS_CYC clk cycles; SPS_CYC ≥ 1.
- PRE_LEN, 8: preamble symbols per frame; PRE_LEN ≥ 1.
- LEN_W, 8: width of frame_len.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  frame request pulse; sampled only in IDLE.
- frame_len  in  LEN_W  data symbols in the frame; latched when start is accepted.
- in_valid  in  1  dibit available.
- in_dibit  in  2  data dibit, {I,Q} bits.
- in_ready  out  1  scheduler takes a dibit this cycle.
- car_en  out  1  carrier generator run enable.
- car_sync  out  1  one-cycle pulse; forces the generator phase counter to 0.
- car_phase  out  2  quarter-period phase offset added to the generator index.
- sym_stb  out  1  pulse on the first cycle of every transmitted symbol.
- busy  out  1  high from start acceptance until the done cycle, inclusive.
- done  out  1  one-cycle pulse at frame end.
- underrun  out  1  sticky: a data boundary arrived with in_valid low.

## Operation
- FSM states: IDLE, SYNC, PRE, DATA, DONE.
- IDLE: car_en=0, in_ready=0. A start with frame_len≠0 latches the length and moves to SYNC. A start with frame_len=0 moves to DONE directly, without SYNC and without carrier activity.
- SYNC lasts 1 cycle: car_sync=1, car_en=0. Next state is PRE, or DATA when the preamble is compiled out.
- PRE: PRE_LEN symbols. car_phase alternates 0,2,0,2,… starting at 0.
- DATA: frame_len symbols. Each symbol's car_phase is the Gray map of its dibit: 00→0, 01→1, 11→2, 10→3.
- Handshake:
  - in_ready is high for exactly one cycle, the cycle before each data symbol starts. That is the last cycle of the preceding symbol, or the SYNC cycle for the first data symbol when there is no preamble.
  - in_ready is never high otherwise.
  - Transfer occurs on in_valid & in_ready.
- Underrun: in_valid low while in_ready is high sets underrun. That symbol is still sent with car_phase=0 and still counts toward frame_len.
- DONE lasts 1 cycle: done=1, car_en=0, car_phase=0, then IDLE.
- underrun clears only on an accepted start.
- start is ignored while busy.
- Symbol count uses LEN_W bits. The tick counter uses clog2(P) bits and wraps at P-1.

## Timing
- Reset values: in_ready=0, car_en=0, car_sync=0, car_phase=0, sym_stb=0, busy=0, done=0, underrun=0; state=IDLE.
- Reset assertion at any point, including mid-frame, forces all outputs to reset values immediately.
- Cycle references, with start sampled at cycle t:
  - SYNC is cycle t+1.
  - Symbol k (0-based, preamble and data combined) begins at t+2+k*P, with sym_stb=1 and car_phase updated on that cycle.
  - car_en goes high at t+2.
  - DONE is cycle t+2+(PRE_LEN+N)*P, where N=frame_len. With the preamble compiled out, PRE_LEN is taken as 0.
- frame_len=0: done at t+1, busy high only at t+1.
- All outputs are registered.

## Configuration
- QPSK_TX_SCHED_PREAMBLE_EN defined: PRE state is present; PRE_LEN preamble symbols precede data.
- QPSK_TX_SCHED_PREAMBLE_EN undefined: PRE state and its counter are removed; SYNC goes to DATA; PRE_LEN is ignored.

## Structure
- Package qpsk_pkg contains:
  - FSM state enum;
  - Gray dibit-to-phase function;
  - phase constants PH_0/PH_90/PH_180/PH_270;
  - preamble phase pattern.
- Sub-module sym_tick_gen: counter modulo P with clear input; outputs sym_first (cycle 0) and sym_last (cycle P-1).

## Test plan
Bench parameters: SPS_CYC=2 (P=8), PRE_LEN=4, macro defined unless stated.
- Reset → every output 0. Release with start=0 → outputs stay 0.
- start at t, frame_len=3, dibits 00,01,11, always valid:
  - car_sync at t+1;
  - phases 0,2,0,2,0,1,2, each held 8 cycles from t+2;
  - in_ready at t+33, t+41, t+49;
  - done at t+58;
  - underrun=0.
- start with frame_len=0 → done at t+1, car_en never high, in_ready never high.
- frame_len=3, in_valid low at the 2nd data in_ready → underrun=1, 2nd data symbol phase 0, done still at t+58. Next start clears underrun.
- Reset mid-frame:
  - start pulse during DATA → ignored, done timing unchanged.
  - rst_n low at t+40 → car_en=0 and busy=0 immediately.
  - New start after release → full frame as in the frame_len=3 scenario.
- Macro undefined, frame_len=2, dibits 10,11:
  - in_ready at t+1;
  - phases 3,2 from t+2;
  - done at t+18.
